score_display: RTL and testbench
================================

// Module: score_display
// PURPOSE
// - Snake-game score keeper: counts good collisions (food), clears on bad collision (wall/self).
// - Converts score to two BCD digits and two 7-segment patterns; also exposes a scanned digit.
// - Sits between collision-detect/button logic and the board's seven-segment displays.
// PARAMETERS
// - MAX_SCORE  99  saturation ceiling of score; must be <= 99 (two BCD digits, 7-bit binary)
// PORTS
// - clk             in   1  system clock
// - rst             in   1  asynchronous, active-high reset
// - goodCollButton  in   1  good collision / food eaten; asynchronous level, edge-detected
// - badCollButton   in   1  bad collision / game over; asynchronous level, edge-detected
// - dispScore       out  7  binary current score, 0..MAX_SCORE
// - bcd_ones        out  4  ones digit of shown score, 0..9
// - bcd_tens        out  4  tens digit of shown score, 0..9
// - ss0             out  7  7-seg pattern of bcd_ones, {g,f,e,d,c,b,a}, active-high
// - ss1             out  7  7-seg pattern of bcd_tens, same encoding
// - displayOut      out  4  scanned digit: bcd_ones when scan=0, bcd_tens when scan=1
// BEHAVIOUR
// - One clock domain; all state flops async-cleared by rst=1.
// - Reset values: score=0, high=0, scan=0, sync flops=0. Outputs: dispScore=0, bcd_*=0,
//   ss0=ss1=7'h3F, displayOut=0.
// - Each input passes through a 2-flop synchronizer, then a rising-edge detector
//   (pulse = sync2 & ~sync2_q).
// - Latency: input rises before edge E1; pulse asserts after E2; score updates at E3.
// - Held level = one event, whatever its duration; a new event needs a low-to-high transition.
// - Good pulse: score <= score+1; at MAX_SCORE score holds (saturates, no wrap).
// - Bad pulse: score <= 0.
// - Good and bad pulse in the same cycle: bad wins, score <= 0.
// - bcd_tens = shown/10, bcd_ones = shown%10; both combinational from registered score.
// - 7-seg table, 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Input codes 10..15 give 7'h00 (blank).
// - scan toggles every clock; displayOut updates same cycle as the BCD digits.
// - Reset mid-operation: state clears immediately and asynchronously.
//   An input still high at reset release is treated as a new edge (sync flops cleared to 0).
// CONFIGURATION
// - HIGH_SCORE_EN defined: register high <= score whenever score > high; never cleared by bad.
//   bcd_*, ss*, displayOut show high; dispScore still shows the current score.
// - HIGH_SCORE_EN undefined: no high register; bcd_*, ss*, displayOut show the current score.
// STRUCTURE
// - Package score_pkg:
//   - SCORE_W = 7, MAX_SCORE_DEF = 99
//   - localparam array SEG_LUT[0:9] of 7-bit patterns
//   - typedef logic [3:0] bcd_t
// - Sub-module seg7_decoder (bcd_t in -> 7-bit pattern out); instantiated twice, for ss0 and ss1.
// - Top holds the synchronizers, edge detectors, score/high registers, binary->BCD split, scan mux.
// TESTING
// - Reset: hold rst=1 for 2 clocks.
//   -> dispScore=0, bcd=0/0, ss0=ss1=7'h3F, displayOut=0.
// - Four separate 1-cycle good pulses, each followed by a low cycle, wait 3 clocks.
//   -> dispScore=4, bcd_ones=4, ss0=7'h66.
// - Good held high for 4 consecutive clocks -> dispScore increments by exactly 1.
// - Score 4, then bad pulse -> dispScore=0 on the third edge after the input rose.
//   Then 2 separate good pulses -> dispScore=2.
//   With HIGH_SCORE_EN: bcd_ones=4, ss0=7'h66.
// - Score 12, good and bad rising together -> dispScore=0.
//   Separately, 105 good pulses -> dispScore saturates at 99, bcd=9/9, ss0=ss1=7'h6F.
// - Score 37 -> displayOut alternates 7,3 every clock.
//   Assert rst mid-count -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types, widths and the 7-segment table for the snake score display.
package score_pkg;

  localparam int SCORE_W       = 7;
  localparam int MAX_SCORE_DEF = 99;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic bcd_t tens_of(input logic [SCORE_W-1:0] v);
    return bcd_t'(v / 7'd10);
  endfunction

  function automatic bcd_t ones_of(input logic [SCORE_W-1:0] v);
    return bcd_t'(v % 7'd10);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to an active-high {g,f,e,d,c,b,a} pattern.
// Codes 10..15 blank the digit.
module seg7_decoder
  import score_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    if (bcd_i <= 4'd9) seg_o = SEG_LUT[bcd_i];
  end

endmodule

// File: rtl/score_display.sv
// Snake score keeper: synced/edge-detected collision inputs, saturating score, BCD + 7-seg out.
// Define HIGH_SCORE_EN to show a sticky high score on the digits instead of the live score.
module score_display
  import score_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               goodCollButton,
  input  logic               badCollButton,
  output logic [SCORE_W-1:0] dispScore,
  output bcd_t               bcd_ones,
  output bcd_t               bcd_tens,
  output logic [6:0]         ss0,
  output logic [6:0]         ss1,
  output bcd_t               displayOut
);

  // [0],[1] form the synchronizer; [2] is the delayed copy for edge detect
  logic [2:0]         good_q;
  logic [2:0]         bad_q;
  logic               good_pulse;
  logic               bad_pulse;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] shown;
  logic               scan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= {good_q[1:0], goodCollButton};
      bad_q  <= {bad_q[1:0], badCollButton};
    end
  end

  assign good_pulse = good_q[1] & ~good_q[2];
  assign bad_pulse  = bad_q[1] & ~bad_q[2];

  always_comb begin
    score_d = score_q;
    if (bad_pulse)
      score_d = '0;
    else if (good_pulse && score_q < SCORE_W'(MAX_SCORE))
      score_d = score_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      scan_q  <= 1'b0;
    end else begin
      score_q <= score_d;
      scan_q  <= ~scan_q;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  high_q <= '0;
    else if (score_q > high_q) high_q <= score_q;
  end

  assign shown = high_q;
`else
  assign shown = score_q;
`endif

  assign dispScore  = score_q;
  assign bcd_tens   = tens_of(shown);
  assign bcd_ones   = ones_of(shown);
  assign displayOut = scan_q ? bcd_tens : bcd_ones;

  seg7_decoder u_seg_ones (
    .bcd_i (bcd_ones),
    .seg_o (ss0)
  );

  seg7_decoder u_seg_tens (
    .bcd_i (bcd_tens),
    .seg_o (ss1)
  );

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: latency, edge detect, saturation, scan, async reset.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       good;
  logic       bad;
  logic [6:0] disp;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] ss0;
  logic [6:0] ss1;
  logic [3:0] dout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  score_display dut (
    .clk            (clk),
    .rst            (rst),
    .goodCollButton (good),
    .badCollButton  (bad),
    .dispScore      (disp),
    .bcd_ones       (ones),
    .bcd_tens       (tens),
    .ss0            (ss0),
    .ss1            (ss1),
    .displayOut     (dout)
  );

  // posedges since reset release; scan phase is cyc[0]
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic good_pulses(input int n);
    repeat (n) begin
      good = 1'b1;
      @(negedge clk);
      good = 1'b0;
      @(negedge clk);
    end
    wait_clks(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_disp"}, disp, 0);
    check({tag, "_ones"}, ones, 0);
    check({tag, "_tens"}, tens, 0);
    check({tag, "_ss0"}, ss0, 'h3F);
    check({tag, "_ss1"}, ss1, 'h3F);
    check({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    rst  = 1'b1;
    good = 1'b0;
    bad  = 1'b0;
    wait_clks(2);
    check_reset_vals("rst");
    rst = 1'b0;
    wait_clks(1);

    good_pulses(4);
    check("four_disp", disp, 4);
    check("four_ones", ones, 4);
    check("four_ss0", ss0, 'h66);
    check("four_ss1", ss1, 'h3F);

    // bad rises before E1, score must clear exactly at E3
    bad = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("bad_e2_hold", disp, 4);
    @(posedge clk);
    #1 check("bad_e3_clr", disp, 0);
    @(negedge clk);
    bad = 1'b0;
    wait_clks(2);

    good_pulses(2);
    check("after_bad_disp", disp, 2);
`ifdef HIGH_SCORE_EN
    check("high_ones", ones, 4);
    check("high_ss0", ss0, 'h66);
`else
    check("live_ones", ones, 2);
    check("live_ss0", ss0, 'h5B);
`endif

    good = 1'b1;
    wait_clks(4);
    good = 1'b0;
    wait_clks(3);
    check("held_once", disp, 3);

    good_pulses(9);
    check("twelve", disp, 12);
    good = 1'b1;
    bad  = 1'b1;
    @(negedge clk);
    good = 1'b0;
    bad  = 1'b0;
    wait_clks(3);
    check("both_bad_wins", disp, 0);

    good_pulses(105);
    check("sat_disp", disp, 99);
    check("sat_ones", ones, 9);
    check("sat_tens", tens, 9);
    check("sat_ss0", ss0, 'h6F);
    check("sat_ss1", ss1, 'h6F);

    do_reset();
    good_pulses(37);
    check("s37_disp", disp, 37);
    check("s37_ss1", ss1, 'h4F);
    check("s37_ss0", ss0, 'h07);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("scan%0d", i), dout, cyc[0] ? 3 : 7);
      @(negedge clk);
    end

    // async reset between edges
    good = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async");
    good = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clks(4);
    check("held_through_rst", disp, 1);
    good = 1'b0;
    wait_clks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
